// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Assembles 5-byte command frames (SYNC, OPCODE, OPERAND_HI, OPERAND_LO,
// CHECKSUM) from the UART receive byte stream. Each frame is verified by an
// XOR checksum. A good frame produces a one-cycle o_cmd_valid pulse with its
// opcode and operand. Corrupted or stalled frames are dropped, and each one
// is reported with a one-cycle error pulse.
//
// Optional build feature: define UART_CMD_PARSER_STATS_EN to add the frame
// and error statistics counters (o_frame_count, o_err_count).
//
// i_data arrives in serial order. i_data[0] is the first bit received, which
// is the byte LSB. It is re-packed into an ordinary [7:0] byte before any
// comparison is made.

module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 240000,
  parameter int         TO_W           = 18
) (
  input  logic        clk,
  input  logic        r_reset,
  input  logic [0:7]  i_data,
  input  logic        i_valid,
  output logic        o_cmd_valid,
  output logic [7:0]  o_opcode,
  output logic [15:0] o_operand,
  output logic        o_err_checksum,
  output logic        o_err_timeout,
  output logic        o_busy
`ifdef UART_CMD_PARSER_STATS_EN
  ,
  output logic [15:0] o_frame_count,
  output logic [7:0]  o_err_count
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_OP  = 3'd1,
    GET_HI  = 3'd2,
    GET_LO  = 3'd3,
    GET_CHK = 3'd4
  } state_t;

  // Last count value before a stalled frame is abandoned.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      op_q, op_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      lo_q, lo_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            err_chk_q, err_chk_d;
  logic            err_to_q, err_to_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [15:0]     operand_q, operand_d;
  logic [7:0]      rx_byte;
  logic [7:0]      exp_chk;

  // Re-pack the serial-order input so that rx_byte[k] carries weight 2^k.
  always_comb begin
    rx_byte = 8'h00;
    for (int k = 0; k < 8; k++) begin
      rx_byte[k] = i_data[k];
    end
  end

  // The checksum the CHECKSUM byte must equal, taken from the stored fields.
  always_comb begin
    exp_chk = op_q ^ hi_q ^ lo_q;
  end

  // Next-state logic for the frame FSM, the inter-byte timeout and the
  // result pulses. All pulses default low and all other registers default
  // to their held value.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cmd_valid_d = 1'b0;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;
    opcode_d    = opcode_q;
    operand_d   = operand_q;

    if (state_q == IDLE) begin
      to_cnt_d = '0;
      if (i_valid && (rx_byte == SYNC_BYTE)) begin
        state_d = GET_OP;
      end
    end else if (i_valid) begin
      // A byte arriving on the terminal-count cycle still counts as in time.
      to_cnt_d = '0;
      case (state_q)
        GET_OP: begin
          op_d    = rx_byte;
          state_d = GET_HI;
        end
        GET_HI: begin
          hi_d    = rx_byte;
          state_d = GET_LO;
        end
        GET_LO: begin
          lo_d    = rx_byte;
          state_d = GET_CHK;
        end
        GET_CHK: begin
          state_d = IDLE;
          if (rx_byte == exp_chk) begin
            cmd_valid_d = 1'b1;
            opcode_d    = op_q;
            operand_d   = {hi_q, lo_q};
          end else begin
            err_chk_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (to_cnt_q == TO_LAST) begin
      err_to_d = 1'b1;
      state_d  = IDLE;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // State, shadow fields and registered outputs. Reset discards any partial
  // frame without producing a pulse.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      op_q        <= 8'h00;
      hi_q        <= 8'h00;
      lo_q        <= 8'h00;
      cmd_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
      opcode_q    <= 8'h00;
      operand_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cmd_valid_q <= cmd_valid_d;
      err_chk_q   <= err_chk_d;
      err_to_q    <= err_to_d;
      opcode_q    <= opcode_d;
      operand_q   <= operand_d;
    end
  end

  assign o_cmd_valid    = cmd_valid_q;
  assign o_err_checksum = err_chk_q;
  assign o_err_timeout  = err_to_q;
  assign o_opcode       = opcode_q;
  assign o_operand      = operand_q;
  assign o_busy         = (state_q != IDLE);

`ifdef UART_CMD_PARSER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Statistics counters. They update on the same edge that raises the
  // matching pulse. The frame count wraps; the error count sticks at 8'hFF.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 8'h00;
    end else begin
      if (cmd_valid_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if ((err_chk_d || err_to_d) && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign o_frame_count = frame_cnt_q;
  assign o_err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Directed bench for uart_cmd_parser with hand-computed expected values.
// The DUT uses TIMEOUT_CYCLES = 100 so that timeouts are short enough to
// exercise. The statistics checks are compiled in when
// UART_CMD_PARSER_STATS_EN is defined.

module tb_uart_cmd_parser;

  logic        clk;
  logic        r_reset;
  logic [0:7]  i_data;
  logic        i_valid;
  logic        o_cmd_valid;
  logic [7:0]  o_opcode;
  logic [15:0] o_operand;
  logic        o_err_checksum;
  logic        o_err_timeout;
  logic        o_busy;
`ifdef UART_CMD_PARSER_STATS_EN
  logic [15:0] o_frame_count;
  logic [7:0]  o_err_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cmdCount   = 0;
  int chkCount   = 0;
  int toCount    = 0;
  int multiCount = 0;

  uart_cmd_parser #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100),
    .TO_W          (7)
  ) dut (
    .clk           (clk),
    .r_reset       (r_reset),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_cmd_valid   (o_cmd_valid),
    .o_opcode      (o_opcode),
    .o_operand     (o_operand),
    .o_err_checksum(o_err_checksum),
    .o_err_timeout (o_err_timeout),
    .o_busy        (o_busy)
`ifdef UART_CMD_PARSER_STATS_EN
    ,
    .o_frame_count (o_frame_count),
    .o_err_count   (o_err_count)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every output pulse, and flag any cycle with more than one pulse.
  always @(negedge clk) begin
    if (o_cmd_valid)    cmdCount++;
    if (o_err_checksum) chkCount++;
    if (o_err_timeout)  toCount++;
    if ((int'(o_cmd_valid) + int'(o_err_checksum) + int'(o_err_timeout)) > 1)
      multiCount++;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one byte for one cycle. Call at a negedge; returns at the next
  // negedge, just after the DUT sampled the byte.
  task automatic applyStimulus(input logic [7:0] value);
    i_valid = 1'b1;
    for (int k = 0; k < 8; k++) i_data[k] = value[k];
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c0, k0, t0, waited;

  initial begin
    r_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (3) @(negedge clk);
    r_reset = 1'b0;

    // Reset state
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_cmd", o_cmd_valid, 0);
    checkOutput("rst_opcode", o_opcode, 0);
    checkOutput("rst_operand", o_operand, 0);
    checkOutput("rst_errs", {o_err_checksum, o_err_timeout}, 0);
`ifdef UART_CMD_PARSER_STATS_EN
    checkOutput("rst_frame_count", o_frame_count, 0);
    checkOutput("rst_err_count", o_err_count, 0);
`endif
    idle(2);

    // Good frame with assorted gaps
    applyStimulus(8'hA5);
    checkOutput("good_busy_after_sync", o_busy, 1);
    idle(2);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    idle(5);
    applyStimulus(8'h34);
    idle(1);
    applyStimulus(8'h27);
    checkOutput("good_cmd", o_cmd_valid, 1);
    checkOutput("good_opcode", o_opcode, 8'h01);
    checkOutput("good_operand", o_operand, 16'h1234);
    checkOutput("good_no_err", {o_err_checksum, o_err_timeout}, 0);
    idle(1);
    checkOutput("good_cmd_single", o_cmd_valid, 0);
    checkOutput("good_busy_after", o_busy, 0);
    idle(2);

    // Bad checksum frames leave the last good result in place
    c0 = cmdCount;
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h12);
    applyStimulus(8'h34); applyStimulus(8'h28);
    checkOutput("badchk_err", o_err_checksum, 1);
    checkOutput("badchk_cmd", o_cmd_valid, 0);
    checkOutput("badchk_opcode", o_opcode, 8'h01);
    checkOutput("badchk_operand", o_operand, 16'h1234);
    idle(1);
    checkOutput("badchk_busy_after", o_busy, 0);
    applyStimulus(8'hA5); applyStimulus(8'h09); applyStimulus(8'h99);
    applyStimulus(8'h98); applyStimulus(8'h00);
    checkOutput("badchk2_err", o_err_checksum, 1);
    checkOutput("badchk2_opcode", o_opcode, 8'h01);
    checkOutput("badchk2_operand", o_operand, 16'h1234);
    idle(2);
    checkOutput("badchk_no_cmd_count", cmdCount - c0, 0);

    // Noise bytes in IDLE, then a frame
    applyStimulus(8'h00);
    checkOutput("noise00_busy", o_busy, 0);
    applyStimulus(8'hFF);
    checkOutput("noiseFF_busy", o_busy, 0);
    idle(1);
    applyStimulus(8'h5A);
    checkOutput("noise5A_busy", o_busy, 0);
    applyStimulus(8'hA5); applyStimulus(8'h07); applyStimulus(8'h00);
    applyStimulus(8'h10); applyStimulus(8'h17);
    checkOutput("noise_cmd", o_cmd_valid, 1);
    checkOutput("noise_opcode", o_opcode, 8'h07);
    checkOutput("noise_operand", o_operand, 16'h0010);
    idle(2);

    // Inter-byte timeout: the pulse comes 100 cycles after the last byte
    k0 = chkCount;
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    waited = 0;
    while (!o_err_timeout && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("timeout_latency", waited, 100);
    checkOutput("timeout_busy", o_busy, 0);
    checkOutput("timeout_no_cmd", o_cmd_valid, 0);
    idle(1);
    checkOutput("timeout_single", o_err_timeout, 0);
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h00);
    applyStimulus(8'h05); applyStimulus(8'h07);
    checkOutput("after_to_cmd", o_cmd_valid, 1);
    checkOutput("after_to_opcode", o_opcode, 8'h02);
    checkOutput("after_to_operand", o_operand, 16'h0005);
    idle(2);

    // A byte on the terminal-count cycle is accepted with no timeout
    t0 = toCount;
    applyStimulus(8'hA5);
    idle(99);
    applyStimulus(8'h01);
    checkOutput("termcnt_busy", o_busy, 1);
    idle(1);
    checkOutput("termcnt_no_timeout", toCount - t0, 0);
    applyStimulus(8'h12); applyStimulus(8'h34); applyStimulus(8'h27);
    checkOutput("termcnt_cmd", o_cmd_valid, 1);
    checkOutput("termcnt_opcode", o_opcode, 8'h01);
    checkOutput("termcnt_operand", o_operand, 16'h1234);
    idle(2);
    checkOutput("no_extra_chk_errs", chkCount - k0, 0);

    // Reset mid-frame discards the partial frame silently
    c0 = cmdCount; k0 = chkCount; t0 = toCount;
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h12);
    r_reset = 1'b1;
    @(negedge clk);
    r_reset = 1'b0;
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_opcode", o_opcode, 0);
    applyStimulus(8'h34); applyStimulus(8'h27);
    idle(2);
    checkOutput("midrst_busy_after", o_busy, 0);
    checkOutput("midrst_no_pulses", (cmdCount - c0) + (chkCount - k0) + (toCount - t0), 0);
    applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'hAB);
    applyStimulus(8'hCD); applyStimulus(8'h65);
    checkOutput("midrst_next_cmd", o_cmd_valid, 1);
    checkOutput("midrst_next_opcode", o_opcode, 8'h03);
    checkOutput("midrst_next_operand", o_operand, 16'hABCD);
    idle(2);

    // Back-to-back frames, SYNC in the cycle right after CHK
    r_reset = 1'b1;
    @(negedge clk);
    r_reset = 1'b0;
    c0 = cmdCount; k0 = chkCount;
    applyStimulus(8'hA5); applyStimulus(8'h0A); applyStimulus(8'h00);
    applyStimulus(8'h01); applyStimulus(8'h0B);
    checkOutput("b2b_first_cmd", o_cmd_valid, 1);
    checkOutput("b2b_first_opcode", o_opcode, 8'h0A);
    applyStimulus(8'hA5); applyStimulus(8'h0B); applyStimulus(8'h00);
    applyStimulus(8'h02); applyStimulus(8'h09);
    checkOutput("b2b_second_cmd", o_cmd_valid, 1);
    checkOutput("b2b_second_operand", o_operand, 16'h0002);
    applyStimulus(8'hA5); applyStimulus(8'h0C); applyStimulus(8'h00);
    applyStimulus(8'h00); applyStimulus(8'h00);
    checkOutput("b2b_bad_err", o_err_checksum, 1);
    idle(2);
    checkOutput("b2b_cmd_count", cmdCount - c0, 2);
    checkOutput("b2b_chk_count", chkCount - k0, 1);
`ifdef UART_CMD_PARSER_STATS_EN
    checkOutput("stats_frame_count", o_frame_count, 2);
    checkOutput("stats_err_count", o_err_count, 1);
`endif

    checkOutput("one_pulse_per_cycle", multiCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
